instr_adder_seq: RTL and testbench

//  Measurement sequencer for the instrumented ring-oscillator adder. Latches operands from the LA bus.

---
 rtl/instr_adder_pkg.sv | 17 +
 rtl/instr_adder_seq.sv | 157 +++++++++++++++
 tb/tb_instr_adder_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_adder_pkg.sv
// Shared widths, settle length and sequencer state encoding for the instrumented adder.
package instr_adder_pkg;

    localparam int OP_W          = 32;
    localparam int COUNT_W       = 32;
    localparam int GATE_W        = 16;
    localparam int SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STOP,
        CAPTURE
    } state_t;

endpackage

// File: rtl/instr_adder_seq.sv
// Ring-oscillator measurement sequencer: latch operands, clear, gate the ring, settle, capture count.
// Latency: accepted start at t -> done_o at t+2*SETTLE_CYCLES+G+1; no backpressure, start ignored while busy.
// Optional INSTR_ADDER_SEQ_REPEAT_EN: back-to-back measurements while continuous_i is held.
module instr_adder_seq
    import instr_adder_pkg::*;
#(
    parameter int OP_W          = instr_adder_pkg::OP_W,
    parameter int COUNT_W       = instr_adder_pkg::COUNT_W,
    parameter int GATE_W        = instr_adder_pkg::GATE_W,
    parameter int SETTLE_CYCLES = instr_adder_pkg::SETTLE_CYCLES
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               continuous_i,
    input  logic [OP_W-1:0]    a_i,
    input  logic [OP_W-1:0]    b_i,
    input  logic [GATE_W-1:0]  gate_cycles_i,
    output logic [OP_W-1:0]    a_input_o,
    output logic [OP_W-1:0]    b_input_o,
    output logic               ring_en_o,
    output logic               cnt_clr_o,
    output logic               cnt_en_o,
    input  logic [COUNT_W-1:0] count_i,
    output logic [COUNT_W-1:0] result_o,
    output logic               done_o,
    output logic               err_o,
    output logic               busy_o
);

    localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GATE_W-1:0]   r_cnt;
    logic [GATE_W-1:0]   w_cnt_nxt;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [GATE_W-1:0]   r_gate;
    logic [COUNT_W-1:0]  r_result;
    logic                r_done;
    logic                r_err;
    logic                w_cnt_zero;
    logic                w_start_ok;
    logic                w_start_zero;
    logic                w_capture;
    logic                w_repeat;

    assign w_cnt_zero   = (r_cnt == '0);
    assign w_start_ok   = (r_state == IDLE) && start_i && !abort_i && (gate_cycles_i != '0);
    assign w_start_zero = (r_state == IDLE) && start_i && !abort_i && (gate_cycles_i == '0);

`ifdef INSTR_ADDER_SEQ_REPEAT_EN
    assign w_repeat = continuous_i;
`else
    logic w_unused_continuous;
    assign w_unused_continuous = continuous_i;
    assign w_repeat = 1'b0;
`endif

    // Each timed state loads N-1 on entry and leaves when the counter reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (abort_i && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        w_state_nxt = LOAD;
                        w_cnt_nxt   = SETTLE_LD;
                    end
                end
                LOAD: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = r_gate - 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = STOP;
                        w_cnt_nxt   = SETTLE_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = CAPTURE;
                        w_capture   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (w_repeat) begin
                        w_state_nxt = LOAD;
                        w_cnt_nxt   = SETTLE_LD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_gate   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_capture | w_start_zero;
            if (w_start_ok) begin
                r_a    <= a_i;
                r_b    <= b_i;
                r_gate <= gate_cycles_i;
                r_err  <= 1'b0;
            end else if (w_start_zero) begin
                r_err <= 1'b1;
            end
            // count_i has been quiescent for the whole STOP window, so no synchronizer.
            if (w_capture) begin
                r_result <= count_i;
            end
        end
    end

    assign a_input_o = r_a;
    assign b_input_o = r_b;
    assign ring_en_o = (r_state == RUN);
    assign cnt_en_o  = (r_state == RUN);
    assign cnt_clr_o = (r_state == LOAD);
    assign busy_o    = (r_state != IDLE);
    assign result_o  = r_result;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_instr_adder_seq.sv
// Scoreboard bench for instr_adder_seq: stimulus pushes expected captures, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_instr_adder_seq;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [15:0] gate_cycles_i = '0;
    logic [31:0] a_input_o;
    logic [31:0] b_input_o;
    logic        ring_en_o;
    logic        cnt_clr_o;
    logic        cnt_en_o;
    logic [31:0] count_i;
    logic [31:0] result_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;

    logic [31:0] cnt_base = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    instr_adder_seq dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_n      (wb_rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .continuous_i  (continuous_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .gate_cycles_i (gate_cycles_i),
        .a_input_o     (a_input_o),
        .b_input_o     (b_input_o),
        .ring_en_o     (ring_en_o),
        .cnt_clr_o     (cnt_clr_o),
        .cnt_en_o      (cnt_en_o),
        .count_i       (count_i),
        .result_o      (result_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .busy_o        (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Core counter model: clear loads a base value, each enabled cycle adds one edge.
    always @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)      count_i <= '0;
        else if (cnt_clr_o) count_i <= cnt_base;
        else if (cnt_en_o)  count_i <= count_i + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (wb_rst_n && done_o) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done_o=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("result", result_o, e.res);
                chk("err_at_done", err_o, e.err);
            end
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge wb_clk_i);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [15:0] g,
                         input logic [31:0] res, input logic err, input int lat, output int c);
        @(negedge wb_clk_i);
        a_i = a;
        b_i = b;
        gate_cycles_i = g;
        start_i = 1'b1;
        c = cyc;
        if (lat > 0) q.push_back('{res, err, cyc + lat});
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(negedge wb_clk_i);
            #1;
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);

        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ring", ring_en_o, 0);
        chk("rst_clr", cnt_clr_o, 0);
        chk("rst_cnt_en", cnt_en_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_a", a_input_o, 0);
        chk("rst_b", b_input_o, 0);

        // Normal measurement, gate 10.
        cnt_base = 32'h1234 - 32'd10;
        issue(32'h0000_00FF, 32'h1, 16'd10, 32'h1234, 1'b0, 19, c);
        chk("load_clr", cnt_clr_o, 1);
        chk("load_ring", ring_en_o, 0);
        chk("load_busy", busy_o, 1);
        chk("load_a", a_input_o, 32'hFF);
        chk("load_b", b_input_o, 32'h1);
        a_i = 32'hDEAD_BEEF;
        gate_cycles_i = 16'd3;
        at(c + 5);
        chk("run_first_ring", ring_en_o, 1);
        chk("run_cnt_en", cnt_en_o, 1);
        chk("run_clr", cnt_clr_o, 0);
        chk("run_a_held", a_input_o, 32'hFF);
        at(c + 14);
        chk("run_last_ring", ring_en_o, 1);
        at(c + 15);
        chk("stop_ring", ring_en_o, 0);
        chk("stop_busy", busy_o, 1);
        drain("normal_drain", 40);

        // Zero gate, then a good start clears err.
        issue(32'h0, 32'h0, 16'd0, 32'h1234, 1'b1, 1, c);
        chk("zero_busy", busy_o, 0);
        chk("zero_err", err_o, 1);
        cnt_base = 32'h100;
        issue(32'h5, 32'h6, 16'd5, 32'h105, 1'b0, 14, c);
        chk("err_cleared", err_o, 0);
        drain("gate5_drain", 40);

        // Minimum gate.
        cnt_base = 32'h7;
        issue(32'h9, 32'hA, 16'd1, 32'h8, 1'b0, 10, c);
        drain("gate1_drain", 40);

        // Abort on the third RUN cycle.
        cnt_base = 32'h50;
        issue(32'h1, 32'h2, 16'd10, 32'h0, 1'b0, 0, c);
        at(c + 7);
        chk("abort_pre_ring", ring_en_o, 1);
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        abort_i = 1'b0;
        chk("abort_ring", ring_en_o, 0);
        chk("abort_cnt_en", cnt_en_o, 0);
        chk("abort_clr", cnt_clr_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_result", result_o, 32'h8);
        repeat (25) @(negedge wb_clk_i);

        // Start with abort in IDLE, then start held across a whole measurement.
        gate_cycles_i = 16'd3;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        chk("start_abort_idle", busy_o, 0);
        abort_i = 1'b0;
        cnt_base = 32'h20;
        c = cyc;
        q.push_back('{32'h23, 1'b0, c + 12});
        at(c + 11);
        start_i = 1'b0;
        drain("held_drain", 40);
        repeat (20) @(negedge wb_clk_i);

        // Continuous mode, gate 2.
        cnt_base = 32'h30;
        continuous_i = 1'b1;
        issue(32'h3, 32'h4, 16'd2, 32'h32, 1'b0, 11, c);
`ifdef INSTR_ADDER_SEQ_REPEAT_EN
        q.push_back('{32'h32, 1'b0, c + 22});
`endif
        at(c + 15);
        continuous_i = 1'b0;
        drain("repeat_drain", 60);
        repeat (30) @(negedge wb_clk_i);
        chk("final_idle", busy_o, 0);
        chk("final_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
